// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Pipelined RV immediate generator with a one-entry skid buffer.
//            Optional CSR-immediate decode enabled by macro IMM_GEN_CSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_FMT_NONE  = 3'd0;
    localparam logic [2:0] c_FMT_I     = 3'd1;
    localparam logic [2:0] c_FMT_S     = 3'd2;
    localparam logic [2:0] c_FMT_B     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_J     = 3'd5;
    localparam logic [2:0] c_FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_CSR_EN
    localparam logic [2:0] c_FMT_CSR   = 3'd7;
`endif

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] w_imm_shamt;
    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_fmt;
    logic            w_dec_ill;

    // RV64 shift amounts carry one extra bit (instr[25]).
    generate
        if (XLEN == 64) begin : g_shamt64
            assign w_imm_shamt = {{(XLEN-6){1'b0}}, in_instr[25:20]};
        end else begin : g_shamt32
            assign w_imm_shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        end
    endgenerate

    always_comb begin
        w_dec_imm = '0;
        w_dec_fmt = c_FMT_NONE;
        w_dec_ill = 1'b0;
        case (in_instr[6:0])
            c_OP_LOAD, c_OP_JALR: begin
                w_dec_fmt = c_FMT_I;
                w_dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            c_OP_IMM: begin
                if (in_instr[13:12] == 2'b01) begin
                    w_dec_fmt = c_FMT_SHAMT;
                    w_dec_imm = w_imm_shamt;
                end else begin
                    w_dec_fmt = c_FMT_I;
                    w_dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                end
            end
            c_OP_STORE: begin
                w_dec_fmt = c_FMT_S;
                w_dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_dec_fmt = c_FMT_B;
                w_dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_dec_fmt = c_FMT_U;
                w_dec_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
            end
            c_OP_JAL: begin
                w_dec_fmt = c_FMT_J;
                w_dec_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            c_OP_REG, c_OP_FENCE: begin
                w_dec_fmt = c_FMT_NONE;
            end
            c_OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
                if (in_instr[14]) begin
                    w_dec_fmt = c_FMT_CSR;
                    w_dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
                end
`endif
            end
            default: begin
                w_dec_ill = 1'b1;
            end
        endcase
    end

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic             out_ill_q, out_ill_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_fmt_q, skid_fmt_d;
    logic             skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;
    logic             w_in_fire;
    logic             w_out_load;

    assign w_in_fire  = in_valid && in_ready_q;
    assign w_out_load = !out_valid_q || out_ready;

    // A full skid forces in_ready low, so skid drain and input accept never coincide.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        if (w_out_load) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_ill_d    = skid_ill_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_in_fire;
                if (w_in_fire) begin
                    out_imm_d = w_dec_imm;
                    out_fmt_d = w_dec_fmt;
                    out_ill_d = w_dec_ill;
                    out_tag_d = in_tag;
                end
            end
        end else if (w_in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = w_dec_imm;
            skid_fmt_d   = w_dec_fmt;
            skid_ill_d   = w_dec_ill;
            skid_tag_d   = in_tag;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= c_FMT_NONE;
            out_ill_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= c_FMT_NONE;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_ill_q;
    assign out_tag     = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Self-checking bench for imm_gen_pipe (honours IMM_GEN_CSR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]      imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decoder: plain integer field extraction on a sign-extended word.
    function automatic exp_t model(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint s;
        longint v;
        s     = longint'($signed(ins));
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tag;
        case (ins[6:0])
            7'h03, 7'h67: begin e.fmt = 3'd1; v = s >>> 20; end
            7'h13: begin
                if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
                    e.fmt = 3'd6;
                    v = (s >> 20) & ((XLEN == 64) ? 63 : 31);
                end else begin
                    e.fmt = 3'd1;
                    v = s >>> 20;
                end
            end
            7'h23: begin e.fmt = 3'd2; v = ((s >>> 25) <<< 5) | ((s >> 7) & 31); end
            7'h63: begin
                e.fmt = 3'd3;
                v = ((s >>> 31) <<< 12) | (((s >> 7) & 1) << 11)
                  | (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1);
            end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = (s >>> 12) <<< 12; end
            7'h6F: begin
                e.fmt = 3'd5;
                v = ((s >>> 31) <<< 20) | (((s >> 12) & 255) << 12)
                  | (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1);
            end
            7'h33, 7'h0F: begin end
            7'h73: begin
`ifdef IMM_GEN_CSR_EN
                if (ins[14]) begin e.fmt = 3'd7; v = (s >> 15) & 31; end
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = (XLEN == 64) ? 64'(v) : (64'(v) & 64'h0000_0000_FFFF_FFFF);
        return e;
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    logic             prev_stall = 1'b0;
    logic [63:0]      prev_imm;
    logic [2:0]       prev_fmt;
    logic             prev_ill;
    logic [TAG_W-1:0] prev_tag;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_imm", 64'(out_imm), prev_imm);
                chk("stall_meta", 64'({out_valid, out_fmt, out_illegal, out_tag}),
                    64'({1'b1, prev_fmt, prev_ill, prev_tag}));
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr, in_tag));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag %0h expected no output", out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_imm", 64'(out_imm), mon_e.imm);
                    chk("sb_fmt", 64'(out_fmt), 64'(mon_e.fmt));
                    chk("sb_illegal", 64'(out_illegal), 64'(mon_e.ill));
                    chk("sb_tag", 64'(out_tag), 64'(mon_e.tag));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_imm   = 64'(out_imm);
            prev_fmt   = out_fmt;
            prev_ill   = out_illegal;
            prev_tag   = out_tag;
        end
    end

    task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        in_instr = ins;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 20 cycles");
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12];
        logic [31:0] r;
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                7'h33, 7'h0F, 7'h73, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    logic [31:0] d_ins [10];
    logic [63:0] d_imm [10];
    logic [2:0]  d_fmt [10];
    logic        d_ill [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d_ins[0] = 32'hFFF00093; d_imm[0] = 64'hFFFF_FFFF;            d_fmt[0] = 3'd1; d_ill[0] = 1'b0;
        d_ins[1] = 32'hFE112E23; d_imm[1] = 64'hFFFF_FFFC;            d_fmt[1] = 3'd2; d_ill[1] = 1'b0;
        d_ins[2] = 32'hFE000CE3; d_imm[2] = 64'hFFFF_FFF8;            d_fmt[2] = 3'd3; d_ill[2] = 1'b0;
        d_ins[3] = 32'h0010006F; d_imm[3] = 64'h0000_0800;            d_fmt[3] = 3'd5; d_ill[3] = 1'b0;
        d_ins[4] = 32'h800000B7;
        d_imm[4] = (XLEN == 64) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000;
        d_fmt[4] = 3'd4; d_ill[4] = 1'b0;
        d_ins[5] = 32'h4030D093; d_imm[5] = 64'h3;                    d_fmt[5] = 3'd6; d_ill[5] = 1'b0;
        d_ins[6] = 32'h01F09093; d_imm[6] = 64'h1F;                   d_fmt[6] = 3'd6; d_ill[6] = 1'b0;
`ifdef IMM_GEN_CSR_EN
        d_ins[7] = 32'h3002D073; d_imm[7] = 64'h5;                    d_fmt[7] = 3'd7; d_ill[7] = 1'b0;
`else
        d_ins[7] = 32'h3002D073; d_imm[7] = 64'h0;                    d_fmt[7] = 3'd0; d_ill[7] = 1'b0;
`endif
        d_ins[8] = 32'h0000007F; d_imm[8] = 64'h0;                    d_fmt[8] = 3'd0; d_ill[8] = 1'b1;
        d_ins[9] = 32'h002081B3; d_imm[9] = 64'h0;                    d_fmt[9] = 3'd0; d_ill[9] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_fmt_ill_tag", 64'({out_fmt, out_illegal, out_tag}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Model pins
        chk("model_beq", model(32'hFE000CE3, 4'd0).imm, 64'hFFFF_FFF8);
        chk("model_jal", model(32'h0010006F, 4'd0).imm, 64'h0000_0800);
        chk("model_sw", model(32'hFE112E23, 4'd0).imm, 64'hFFFF_FFFC);
        chk("model_srai", model(32'h4030D093, 4'd0).imm, 64'h3);

        // Directed vectors, one cycle latency, back to back
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("dir%0d_in_ready", i), 64'(in_ready), 64'd1);
            in_instr = d_ins[i];
            in_tag   = TAG_W'(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("dir%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("dir%0d_imm", i), 64'(out_imm), d_imm[i]);
            chk($sformatf("dir%0d_fmt", i), 64'(out_fmt), 64'(d_fmt[i]));
            chk($sformatf("dir%0d_illegal", i), 64'(out_illegal), 64'(d_ill[i]));
        end
        @(posedge clk); #1;

        // Back-pressure: 4 tagged instructions, out_ready low for 3 cycles
        fork
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(32'hFFF00093, 4'd0);
                send(32'hFE112E23, 4'd1);
                chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
                chk("bp_hold_tag0", 64'(out_tag), 64'd0);
                send(32'h4030D093, 4'd2);
                send(32'h800000B7, 4'd3);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with skid full and output stalled
        out_ready = 1'b0;
        send(32'h0010006F, 4'd5);
        send(32'hFE000CE3, 4'd6);
        chk("rst_pre_skid_full", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_imm_tag", 64'({out_imm, out_tag}), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'hFFF00093;
        in_tag    = 4'd9;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("post_rst_tag", 64'(out_tag), 64'd9);
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
